ct_ifu_vector_gen: RTL and testbench

//  Parametrised IFU vector/redirect engine. Turns RTU exceptions and interrupts into a

---
 rtl/ct_ifu_vector_gen_pkg.sv | 10 +
 rtl/ct_ifu_vector_tgt.sv | 38 +++
 rtl/gated_clk_cell.sv | 20 ++
 rtl/ct_ifu_vector_gen.sv | 146 ++++++++++++++
 tb/tb_ct_ifu_vector_gen.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ct_ifu_vector_gen_pkg.sv
// ct_ifu_vector_gen_pkg: one-hot state encodings and vbr mode codes shared by the IFU vector engine
package ct_ifu_vector_gen_pkg;
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_RESET  = 4'b0010,
    ST_CALC   = 4'b0100,
    ST_PCLOAD = 4'b1000
  } vec_st_e;
  localparam logic [1:0] MODE_VECT = 2'b01;
endpackage

// File: rtl/ct_ifu_vector_tgt.sv
// ct_ifu_vector_tgt: vbr set select and redirect-target adder
//   vbr_flat  all vbr sets, set i at [i*PC_WIDTH +: PC_WIDTH]
//   priv      target privilege; out-of-range falls back to set 0
//   vbr       captured vbr used for the target computation
//   vec       captured {int, cause}
//   rst_pc    reset vector in halfword units
//   vbr_sel   vbr set picked by priv
//   tgt       redirect target in halfword units
module ct_ifu_vector_tgt
  import ct_ifu_vector_gen_pkg::*;
#(
  parameter int PC_WIDTH = 40,
  parameter int VEC_W    = 5,
  parameter int NUM_PRIV = 2,
  parameter int PRIV_W   = 1
) (
  input  logic [NUM_PRIV*PC_WIDTH-1:0] vbr_flat,
  input  logic [PRIV_W-1:0]            priv,
  input  logic [PC_WIDTH-1:0]          vbr,
  input  logic [VEC_W:0]               vec,
  input  logic [PC_WIDTH-2:0]          rst_pc,
  output logic [PC_WIDTH-1:0]          vbr_sel,
  output logic [PC_WIDTH-2:0]          tgt
);
  logic [PC_WIDTH-2:0] base;
  logic [PC_WIDTH-2:0] ofs;
  always_comb begin
    vbr_sel = vbr_flat[PC_WIDTH-1:0];
    for (int i = 1; i < NUM_PRIV; i++)
      if (32'(priv) == i) vbr_sel = vbr_flat[i*PC_WIDTH +: PC_WIDTH];
  end
  assign base = {vbr[PC_WIDTH-1:2], 1'b0};
  // 4-byte vector entries are two halfwords, so the cause is shifted by one
  assign ofs  = (PC_WIDTH-1)'({vec[VEC_W-1:0], 1'b0});
  // sum is truncated to the halfword PC width, wrapping at the top of the VA
  assign tgt  = ~|vec ? rst_pc :
                (vbr[1:0] == MODE_VECT && vec[VEC_W]) ? base + ofs : base;
endmodule

// File: rtl/gated_clk_cell.sv
// gated_clk_cell: latch-based clock gate, enable captured while clk_in is low
//   clk_in             free-running clock
//   global_en          global gate enable, qualifies module_en/local_en
//   module_en          forces the clock on when set with global_en
//   local_en           functional enable from the owning block
//   pad_yy_icg_scan_en scan override, clock always on
//   clk_out            gated clock
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic en_lat;
  always_latch
    if (!clk_in) en_lat = (global_en & (module_en | local_en)) | pad_yy_icg_scan_en;
  assign clk_out = clk_in & en_lat;
endmodule

// File: rtl/ct_ifu_vector_gen.sv
// ct_ifu_vector_gen: IFU vector/redirect engine, exception redirect and reset invalidate sequencing
//   forever_cpuclk/cpurst_b          clock and async active-low reset
//   cp0_yy_clk_en/cp0_ifu_icg_en     clock-gate controls, pad_yy_icg_scan_en scan override
//   cp0_ifu_rvbr                     reset vector base
//   cp0_ifu_vbr_flat                 per-privilege vbr sets, [1:0] is the mode
//   cp0_ifu_rst_inv_done             icache invalidate complete
//   rtu_ifu_xx_expt_*                exception/interrupt redirect request
//   rtu_ifu_xx_dbgon                 debug entry, drops any pending redirect
//   ifu_cp0_rst_inv_req              one-cycle invalidate request
//   vector_pcgen_pc/pcload           redirect PC (halfword units) and its load strobe
//   *_reset_on/ifu_xx_sync_reset     high while in RESET
//   vector_ifctrl_sm_on/sm_start     engine busy indications
//   vector_debug_*                   one-hot state and saturating retry count
module ct_ifu_vector_gen
  import ct_ifu_vector_gen_pkg::*;
#(
  parameter int PC_WIDTH    = 40,
  parameter int VEC_W       = 5,
  parameter int NUM_PRIV    = 2,
  parameter int INV_TIMEOUT = 255,
  parameter int RETRY_W     = 4,
  parameter int PRIV_W      = (NUM_PRIV > 1) ? $clog2(NUM_PRIV) : 1
) (
  input  logic                         forever_cpuclk,
  input  logic                         cpurst_b,
  input  logic                         cp0_yy_clk_en,
  input  logic                         cp0_ifu_icg_en,
  input  logic                         pad_yy_icg_scan_en,
  input  logic [PC_WIDTH-1:0]          cp0_ifu_rvbr,
  input  logic [NUM_PRIV*PC_WIDTH-1:0] cp0_ifu_vbr_flat,
  input  logic                         cp0_ifu_rst_inv_done,
  input  logic                         rtu_ifu_xx_expt_vld,
  input  logic [VEC_W:0]               rtu_ifu_xx_expt_vec,
  input  logic [PRIV_W-1:0]            rtu_ifu_xx_expt_priv,
  input  logic                         rtu_ifu_xx_dbgon,
  output logic                         ifu_cp0_rst_inv_req,
  output logic                         ifu_xx_sync_reset,
  output logic [PC_WIDTH-2:0]          vector_pcgen_pc,
  output logic                         vector_pcgen_pcload,
  output logic                         vector_pcgen_reset_on,
  output logic                         vector_ifctrl_reset_on,
  output logic                         vector_ifctrl_sm_on,
  output logic                         vector_ifctrl_sm_start,
  output logic [3:0]                   vector_debug_cur_st,
  output logic [RETRY_W-1:0]           vector_debug_inv_retry
);
  localparam int CNT_W = $clog2(INV_TIMEOUT);
  vec_st_e             state_q, state_d;
  logic                entered_q, entered_d;
  logic                retry_req_q, retry_req_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_q, retry_d;
  logic [VEC_W:0]      vec_q, vec_d;
  logic [PC_WIDTH-1:0] vbr_q, vbr_d, vbr_sel;
  logic [PC_WIDTH-2:0] pc_q, pc_d, tgt, rst_pc;
  logic                is_rst, is_idle, is_calc, is_pcload;
  logic                rst_done, timeout, capture, sm_clk, pc_clk, unused_rvbr0;
  assign is_rst       = state_q == ST_RESET;
  assign is_idle      = state_q == ST_IDLE;
  assign is_calc      = state_q == ST_CALC;
  assign is_pcload    = state_q == ST_PCLOAD;
  assign rst_pc       = cp0_ifu_rvbr[PC_WIDTH-1:1];
  assign unused_rvbr0 = cp0_ifu_rvbr[0];
  assign rst_done     = is_rst & cp0_ifu_rst_inv_done;
  assign timeout      = is_rst & ~cp0_ifu_rst_inv_done & (cnt_q == CNT_W'(INV_TIMEOUT - 1));
  // redirects are never taken in RESET so the invalidate always completes
  assign capture      = rtu_ifu_xx_expt_vld & ~is_rst & ~rtu_ifu_xx_dbgon;
  gated_clk_cell x_sm_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_ifu_icg_en),
    .local_en           (rtu_ifu_xx_expt_vld | ~is_idle),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (sm_clk)
  );
  gated_clk_cell x_pc_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_ifu_icg_en),
    .local_en           (capture | is_calc | rst_done),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (pc_clk)
  );
  ct_ifu_vector_tgt #(
    .PC_WIDTH (PC_WIDTH),
    .VEC_W    (VEC_W),
    .NUM_PRIV (NUM_PRIV),
    .PRIV_W   (PRIV_W)
  ) x_tgt (
    .vbr_flat (cp0_ifu_vbr_flat),
    .priv     (rtu_ifu_xx_expt_priv),
    .vbr      (vbr_q),
    .vec      (vec_q),
    .rst_pc   (rst_pc),
    .vbr_sel  (vbr_sel),
    .tgt      (tgt)
  );
  always_comb begin
    state_d     = is_rst ? (cp0_ifu_rst_inv_done ? ST_IDLE : ST_RESET) :
                  rtu_ifu_xx_dbgon    ? ST_IDLE :
                  rtu_ifu_xx_expt_vld ? ST_CALC :
                  is_calc             ? ST_PCLOAD : ST_IDLE;
    entered_d   = entered_q | is_rst;
    retry_req_d = timeout;
    cnt_d       = (is_rst & ~cp0_ifu_rst_inv_done & ~timeout) ? cnt_q + CNT_W'(1) : '0;
    retry_d     = retry_q + RETRY_W'(timeout & ~&retry_q);
    vec_d       = capture ? rtu_ifu_xx_expt_vec : vec_q;
    vbr_d       = capture ? vbr_sel : vbr_q;
    pc_d        = is_rst ? rst_pc : is_calc ? tgt : pc_q;
  end
  always_ff @(posedge sm_clk or negedge cpurst_b)
    if (!cpurst_b) begin
      state_q     <= ST_RESET;
      entered_q   <= 1'b0;
      retry_req_q <= 1'b0;
      cnt_q       <= '0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      entered_q   <= entered_d;
      retry_req_q <= retry_req_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
    end
  always_ff @(posedge pc_clk or negedge cpurst_b)
    if (!cpurst_b) begin
      vec_q <= '0;
      vbr_q <= '0;
      pc_q  <= '0;
    end else begin
      vec_q <= vec_d;
      vbr_q <= vbr_d;
      pc_q  <= pc_d;
    end
  // first RESET cycle issues the request; timeouts re-issue it a cycle later
  assign ifu_cp0_rst_inv_req    = (is_rst & ~entered_q) | retry_req_q;
  assign ifu_xx_sync_reset      = is_rst;
  assign vector_pcgen_reset_on  = is_rst;
  assign vector_ifctrl_reset_on = is_rst;
  assign vector_ifctrl_sm_on    = ~is_idle;
  assign vector_ifctrl_sm_start = (~is_idle & ~is_rst) | rtu_ifu_xx_expt_vld;
  assign vector_pcgen_pcload    = rst_done | (is_pcload & ~rtu_ifu_xx_expt_vld & ~rtu_ifu_xx_dbgon);
  assign vector_pcgen_pc        = rst_done ? rst_pc : pc_q;
  assign vector_debug_cur_st    = state_q;
  assign vector_debug_inv_retry = retry_q;
endmodule

// File: tb/tb_ct_ifu_vector_gen.sv
// tb_ct_ifu_vector_gen: directed table and sequence checks of the IFU vector engine
module tb_ct_ifu_vector_gen;
  localparam logic [3:0] S_IDLE = 4'b0001, S_RESET = 4'b0010, S_CALC = 4'b0100, S_PCLOAD = 4'b1000;
  logic        clk, rst_b, clk_en, icg_en, scan_en, done, vld, dbgon, priv;
  logic [39:0] rvbr;
  logic [79:0] vbr_flat;
  logic [5:0]  vec;
  logic        inv_req, sync_reset, pcload, p_reset_on, i_reset_on, sm_on, sm_start;
  logic [38:0] pc;
  logic [3:0]  cur_st, retry;
  int total = 0, bad = 0;
  typedef struct {
    logic [39:0] vbr0;
    logic [39:0] vbr1;
    logic [5:0]  vec;
    logic        priv;
    logic [38:0] pc;
  } vec_rec_t;
  vec_rec_t tbl[8];
  ct_ifu_vector_gen #(.INV_TIMEOUT(8)) dut (
    .forever_cpuclk         (clk),
    .cpurst_b               (rst_b),
    .cp0_yy_clk_en          (clk_en),
    .cp0_ifu_icg_en         (icg_en),
    .pad_yy_icg_scan_en     (scan_en),
    .cp0_ifu_rvbr           (rvbr),
    .cp0_ifu_vbr_flat       (vbr_flat),
    .cp0_ifu_rst_inv_done   (done),
    .rtu_ifu_xx_expt_vld    (vld),
    .rtu_ifu_xx_expt_vec    (vec),
    .rtu_ifu_xx_expt_priv   (priv),
    .rtu_ifu_xx_dbgon       (dbgon),
    .ifu_cp0_rst_inv_req    (inv_req),
    .ifu_xx_sync_reset      (sync_reset),
    .vector_pcgen_pc        (pc),
    .vector_pcgen_pcload    (pcload),
    .vector_pcgen_reset_on  (p_reset_on),
    .vector_ifctrl_reset_on (i_reset_on),
    .vector_ifctrl_sm_on    (sm_on),
    .vector_ifctrl_sm_start (sm_start),
    .vector_debug_cur_st    (cur_st),
    .vector_debug_inv_retry (retry)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_b = 1'b0;
    vld = 1'b0;
    dbgon = 1'b0;
    done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", cur_st, S_RESET);
    chk("rst_pcload", pcload, 1'b0);
    chk("rst_pc", pc, 39'h0);
    chk("rst_retry", retry, 4'h0);
    chk("rst_sync_reset", {sync_reset, p_reset_on, i_reset_on, sm_on}, 4'hF);
    cyc();
    rst_b = 1'b1;
  endtask
  task automatic expt(input logic [5:0] v);
    vld = 1'b1;
    vec = v;
  endtask
  initial begin
    tbl[0] = '{40'h00_8000_0001, 40'h0,            6'h23, 1'b0, 39'h00_4000_0006};
    tbl[1] = '{40'h00_8000_0000, 40'h0,            6'h23, 1'b0, 39'h00_4000_0000};
    tbl[2] = '{40'h00_8000_0001, 40'h00_9000_0000, 6'h23, 1'b1, 39'h00_4800_0000};
    tbl[3] = '{40'h00_8000_0001, 40'h0,            6'h03, 1'b0, 39'h00_4000_0000};
    tbl[4] = '{40'hFF_FFFF_FFFD, 40'h0,            6'h3F, 1'b0, 39'h00_0000_003C};
    tbl[5] = '{40'h00_8000_0001, 40'h0,            6'h00, 1'b0, 39'h00_0800_0000};
    tbl[6] = '{40'h0,            40'h20_0000_0105, 6'h2A, 1'b1, 39'h10_0000_0096};
    tbl[7] = '{40'h00_1234_5677, 40'h0,            6'h23, 1'b0, 39'h00_091A_2B3A};
    clk = 1'b0;
    clk_en = 1'b1;
    icg_en = 1'b0;
    scan_en = 1'b0;
    rvbr = 40'h00_1000_0000;
    vbr_flat = '0;
    vec = '0;
    priv = 1'b0;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      done = (k == 5);
      @(negedge clk);
      chk("a_inv_req", inv_req, k == 0);
      chk("a_pcload", pcload, k == 5);
      if (k == 5) chk("a_pc", pc, 39'h00_0800_0000);
      cyc();
    end
    done = 1'b0;
    @(negedge clk);
    chk("a_idle", cur_st, S_IDLE);
    chk("a_idle_pcload", pcload, 1'b0);
    chk("a_retry", retry, 4'h0);
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      done = (k == 20);
      vld = (k == 3);
      dbgon = (k == 4);
      @(negedge clk);
      chk("b_inv_req", inv_req, (k == 0) || (k == 8) || (k == 16));
      chk("b_sync_reset", sync_reset, 1'b1);
      chk("b_pcload", pcload, k == 20);
      if (k == 20) chk("b_pc", pc, 39'h00_0800_0000);
      cyc();
    end
    done = 1'b0;
    vld = 1'b0;
    dbgon = 1'b0;
    @(negedge clk);
    chk("b_idle", cur_st, S_IDLE);
    chk("b_retry", retry, 4'h2);
    cyc();
    foreach (tbl[i]) begin
      vbr_flat = {tbl[i].vbr1, tbl[i].vbr0};
      priv = tbl[i].priv;
      expt(tbl[i].vec);
      @(negedge clk);
      chk("t_start", sm_start, 1'b1);
      cyc();
      vld = 1'b0;
      @(negedge clk);
      chk("t_calc", cur_st, S_CALC);
      chk("t_calc_pcload", pcload, 1'b0);
      cyc();
      @(negedge clk);
      chk("t_pcload", pcload, 1'b1);
      chk("t_pc", pc, tbl[i].pc);
      cyc();
      @(negedge clk);
      chk("t_idle", {cur_st, pcload}, {S_IDLE, 1'b0});
      cyc();
    end
    vbr_flat = {40'h0, 40'h00_8000_0001};
    priv = 1'b0;
    expt(6'h23);
    cyc();
    expt(6'h21);
    @(negedge clk);
    chk("c_t1", {cur_st, pcload}, {S_CALC, 1'b0});
    cyc();
    vld = 1'b0;
    @(negedge clk);
    chk("c_t2", {cur_st, pcload}, {S_CALC, 1'b0});
    cyc();
    @(negedge clk);
    chk("c_t3_pcload", pcload, 1'b1);
    chk("c_t3_pc", pc, 39'h00_4000_0002);
    cyc();
    expt(6'h23);
    cyc();
    vld = 1'b0;
    cyc();
    expt(6'h22);
    @(negedge clk);
    chk("e_t2", {cur_st, pcload}, {S_PCLOAD, 1'b0});
    cyc();
    vld = 1'b0;
    @(negedge clk);
    chk("e_t3", {cur_st, pcload}, {S_CALC, 1'b0});
    cyc();
    @(negedge clk);
    chk("e_t4_pcload", pcload, 1'b1);
    chk("e_t4_pc", pc, 39'h00_4000_0004);
    cyc();
    expt(6'h23);
    cyc();
    vld = 1'b0;
    dbgon = 1'b1;
    @(negedge clk);
    chk("d_t1_pcload", pcload, 1'b0);
    cyc();
    dbgon = 1'b0;
    @(negedge clk);
    chk("d_t2", {cur_st, pcload}, {S_IDLE, 1'b0});
    cyc();
    @(negedge clk);
    chk("d_t3", {cur_st, pcload}, {S_IDLE, 1'b0});
    cyc();
    expt(6'h23);
    cyc();
    vld = 1'b0;
    cyc();
    dbgon = 1'b1;
    @(negedge clk);
    chk("d2_pcload", {cur_st, pcload}, {S_PCLOAD, 1'b0});
    cyc();
    dbgon = 1'b0;
    @(negedge clk);
    chk("d2_idle", {cur_st, pcload}, {S_IDLE, 1'b0});
    cyc();
    expt(6'h23);
    cyc();
    vld = 1'b0;
    #2 rst_b = 1'b0;
    @(negedge clk);
    chk("f_state", cur_st, S_RESET);
    chk("f_pcload", pcload, 1'b0);
    chk("f_pc", pc, 39'h0);
    chk("f_retry", retry, 4'h0);
    chk("f_sync_reset", sync_reset, 1'b1);
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
